ollar_control_fsm: RTL

Fetch/execute sequencer for the OLLAR core. Owns the program counter and instruction register, arbitrates the core's single memory port between instruction fetch, immediate-word fetch and LD/ST data access, and drives register-file read/write controls. Sits between the memory/peripheral pins and the general-purpose register array, executing one instruction at a time.

---
 rtl/ollar_control_fsm_if.sv | 19 +
 rtl/ollar_control_fsm.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ollar_control_fsm_if.sv
// rtl/ollar_control_fsm_if.sv - OLLAR single-port memory bus between sequencer and memory/peripherals
interface ollar_control_fsm_if;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;
  logic        MEM_READY;

  modport master (
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
    input  MEM_RDATA, MEM_READY
  );

  modport slave (
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
    output MEM_RDATA, MEM_READY
  );
endinterface

// File: rtl/ollar_control_fsm.sv
// rtl/ollar_control_fsm.sv - OLLAR fetch/execute sequencer; OLLAR_TRAP_EN enables the illegal-opcode trap
module ollar_control_fsm #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLOCK_PIN,
  input  logic        RESET_PIN,
  ollar_control_fsm_if.master bus,
  output logic [4:0]  RF_RADDR_A,
  output logic [4:0]  RF_RADDR_B,
  input  logic [31:0] RF_RDATA_A,
  input  logic [31:0] RF_RDATA_B,
  output logic        RF_WE,
  output logic [4:0]  RF_WADDR,
  output logic [31:0] RF_WDATA,
  output logic [31:0] PC_OUT,
  output logic        HALT_ERR
);

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_JMP = 8'h01;
  localparam logic [7:0] OP_LD  = 8'h02;
  localparam logic [7:0] OP_ST  = 8'h03;
  localparam logic [7:0] OP_SET = 8'h04;
  localparam logic [7:0] OP_CLR = 8'h05;
  localparam logic [7:0] OP_ADD = 8'h40;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_IMM,
    S_MEM
`ifdef OLLAR_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  // IR[8:0] is never decoded, so only the upper bits are kept.
  logic [31:9] ir_q, ir_d;

  logic        mem_req, mem_we, rf_we;
  logic [31:0] mem_addr, mem_wdata, rf_wdata;
  logic [7:0]  opcode;

  assign opcode     = ir_q[31:24];
  assign RF_WADDR   = ir_q[23:19];
  assign RF_RADDR_A = ir_q[18:14];
  assign RF_RADDR_B = ir_q[13:9];
  assign PC_OUT     = pc_q;

  always_ff @(posedge CLOCK_PIN) begin
    if (RESET_PIN) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_VECTOR;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = 32'h0;
    rf_we     = 1'b0;
    rf_wdata  = 32'h0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.MEM_READY) begin
          ir_d    = bus.MEM_RDATA[31:9];
          pc_d    = pc_q + 32'd1;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (opcode)
          OP_NOP: state_d = S_FETCH;
          OP_CLR: begin
            rf_we   = 1'b1;
            state_d = S_FETCH;
          end
          OP_ADD: begin
            rf_we    = 1'b1;
            rf_wdata = RF_RDATA_A + RF_RDATA_B;
            state_d  = S_FETCH;
          end
          OP_SET, OP_JMP: state_d = S_IMM;
          OP_LD, OP_ST:   state_d = S_MEM;
          default: begin
`ifdef OLLAR_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end

      S_IMM: begin
        mem_req = 1'b1;
        if (bus.MEM_READY) begin
          if (opcode == OP_SET) begin
            rf_we    = 1'b1;
            rf_wdata = bus.MEM_RDATA;
            pc_d     = pc_q + 32'd1;
          end else begin
            pc_d = bus.MEM_RDATA;
          end
          state_d = S_FETCH;
        end
      end

      // Address comes straight from the register file; it stays stable
      // through wait states because nothing writes the RF meanwhile.
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = RF_RDATA_A;
        if (opcode == OP_ST) begin
          mem_we    = 1'b1;
          mem_wdata = RF_RDATA_B;
        end
        if (bus.MEM_READY) begin
          if (opcode == OP_LD) begin
            rf_we    = 1'b1;
            rf_wdata = bus.MEM_RDATA;
          end
          state_d = S_FETCH;
        end
      end

`ifdef OLLAR_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif

      default: state_d = S_FETCH;
    endcase

    // An access in flight during reset is dropped with no side effects.
    if (RESET_PIN) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      rf_we   = 1'b0;
    end
  end

  assign bus.MEM_REQ   = mem_req;
  assign bus.MEM_WE    = mem_we;
  assign bus.MEM_ADDR  = mem_addr;
  assign bus.MEM_WDATA = mem_wdata;
  assign RF_WE         = rf_we;
  assign RF_WDATA      = rf_wdata;

`ifdef OLLAR_TRAP_EN
  assign HALT_ERR = (state_q == S_TRAP);
`else
  assign HALT_ERR = 1'b0;
`endif

endmodule
